modadd_stream: RTL

//  Streaming modular adder C = (A + B) mod Q for Kyber coefficients (Q = 3329).

---
 rtl/modadd_stream.sv | 80 ++++++++
 1 files changed

// File: rtl/modadd_stream.sv
// modadd_stream: 2-stage valid/ready streaming adder C = (A + B) mod Q for Kyber coefficients
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_a, in_b       operand pair input, operands < Q
//   out_valid/out_ready, out_c          result output
//   out_idx, out_last                   coefficient index 0..N-1, high on index N-1
//   range_err                           sticky out-of-range flag, only with MODADD_RANGE_CHECK_EN
module modadd_stream #(
  parameter int Q  = 3329,
  parameter int W  = 12,
  parameter int N  = 256,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_c,
  output logic [CW-1:0] out_idx,
  output logic          out_last
`ifdef MODADD_RANGE_CHECK_EN
  ,
  output logic          range_err
`endif
);
  logic          en1, en2;
  logic [W:0]    sum;
  logic          s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [W-1:0]  r_q, r_d, rq_q, rq_d, c_q, c_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] idx_q, idx_d;
  // neg is the sign of R - Q and rq its low W bits; together they select the reduced sum
  always_comb begin
    en2    = ~s2_v_q | out_ready;
    en1    = ~s1_v_q | en2;
    sum    = {1'b0, in_a} + {1'b0, in_b};
    s1_v_d = en1 ? in_valid : s1_v_q;
    r_d    = en1 ? sum[W-1:0] : r_q;
    rq_d   = en1 ? sum[W-1:0] - W'(Q) : rq_q;
    neg_d  = en1 ? sum < (W+1)'(Q) : neg_q;
    s2_v_d = en2 ? s1_v_q : s2_v_q;
    c_d    = en2 ? (neg_q ? r_q : rq_q) : c_q;
    idx_d  = (s2_v_q & out_ready) ? (idx_q == CW'(N-1) ? '0 : idx_q + CW'(1)) : idx_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      r_q    <= '0;
      rq_q   <= '0;
      neg_q  <= 1'b0;
      c_q    <= '0;
      idx_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      r_q    <= r_d;
      rq_q   <= rq_d;
      neg_q  <= neg_d;
      c_q    <= c_d;
      idx_q  <= idx_d;
    end
`ifdef MODADD_RANGE_CHECK_EN
  logic range_err_q, range_err_d;
  always_comb range_err_d = range_err_q | (in_valid & en1 & (in_a >= W'(Q) | in_b >= W'(Q)));
  always_ff @(posedge clk or negedge reset)
    if (!reset) range_err_q <= 1'b0;
    else        range_err_q <= range_err_d;
  assign range_err = range_err_q;
`endif
  // in_ready is combinational from out_ready so a full pipe drains and refills in one cycle
  assign in_ready  = en1;
  assign out_valid = s2_v_q;
  assign out_c     = c_q;
  assign out_idx   = idx_q;
  assign out_last  = s2_v_q & (idx_q == CW'(N-1));
endmodule
